// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates fetch and load/store access to one shared word memory.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              mem_Clk,
  input  logic              mem_Rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  localparam int                 c_STV_W    = $clog2(STARVE_MAX + 1);
  localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_MAX);
  localparam logic [2:0]         c_LAT_LAST = 3'(READ_LAT - 1);
  localparam logic [32:0]        c_ADDR_MAX = (33'd1 << ADDR_W) - 33'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sel_fetch;
  logic [2:0]         r_lat_cnt;
  logic [c_STV_W-1:0] r_starve_cnt;
  logic               w_grant;
  logic               w_grant_fetch;
  logic               w_bad;
  logic [31:0]        w_win_addr;

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_grant       = 1'b0;
    w_grant_fetch = 1'b0;
    w_state_nxt   = r_state;
    if (r_state == S_IDLE) begin
      w_grant       = if_req | d_req;
      // Data has priority until fetch has watched STARVE_MAX data grants go by
      w_grant_fetch = if_req & (~d_req | (r_starve_cnt == c_STV_MAX));
    end
    w_win_addr = w_grant_fetch ? if_addr : d_addr;
    w_bad      = (w_win_addr[1:0] != 2'b00) || ({1'b0, w_win_addr} > c_ADDR_MAX);
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = w_bad ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = m_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_lat_cnt == c_LAT_LAST) w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      r_state      <= S_IDLE;
      r_sel_fetch  <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      if_ready     <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_ready      <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      m_en         <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_fetch || !if_req)
            r_starve_cnt <= '0;
          else if (w_grant && (r_starve_cnt != c_STV_MAX))
            r_starve_cnt <= r_starve_cnt + 1'b1;
          if (w_grant) begin
            r_sel_fetch <= w_grant_fetch;
            if (w_bad) begin
              // Rejected addresses never reach the memory; answer straight away
              if (w_grant_fetch) begin
                if_ready <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end else begin
                d_ready <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end
            end else begin
              m_en    <= 1'b1;
              m_we    <= ~w_grant_fetch & d_we;
              m_addr  <= w_win_addr[ADDR_W-1:0];
              m_wdata <= w_grant_fetch ? 32'h0 : d_wdata;
            end
          end
        end
        S_ISSUE: begin
          r_lat_cnt <= '0;
          if (m_we) begin
            d_ready <= 1'b1;
            d_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (r_lat_cnt == c_LAT_LAST) begin
            if (r_sel_fetch) begin
              if_ready <= 1'b1;
              if_err   <= 1'b0;
              if_rdata <= m_rdata;
            end else begin
              d_ready <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= m_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Testbench for mem_port_arbiter: directed scenarios plus randomized two-agent traffic
// checked against a word-level memory model and the starvation-rule grant sequence.
module tb_mem_port_arbiter;

  logic        mem_Clk = 1'b0;
  logic        mem_Rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ready, if_err, d_ready, d_err, m_en, m_we, busy;
  logic [31:0] if_rdata, d_rdata, m_wdata, m_rdata;
  logic [15:0] m_addr;

  int total = 0;
  int bad   = 0;
  int cyc_now = 0;
  int m_en_cnt = 0;
  int men_q[$];

  always #5 mem_Clk = ~mem_Clk;

  mem_port_arbiter #(.ADDR_W(16), .READ_LAT(1), .STARVE_MAX(4)) u_dut (
    .mem_Clk(mem_Clk), .mem_Rst_n(mem_Rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  // Byte-wide big-endian memory stub with one cycle of read latency
  logic [7:0] mem [0:65535];
  always @(posedge mem_Clk) begin
    cyc_now <= cyc_now + 1;
    if (m_en) begin
      m_en_cnt <= m_en_cnt + 1;
      men_q.push_back(cyc_now);
    end
    if (m_en && !m_we)
      m_rdata <= {mem[m_addr], mem[16'(m_addr + 16'd1)], mem[16'(m_addr + 16'd2)], mem[16'(m_addr + 16'd3)]};
    else
      m_rdata <= 32'hBADC0DE0;
    if (m_en && m_we) begin
      mem[m_addr]                <= m_wdata[31:24];
      mem[16'(m_addr + 16'd1)]   <= m_wdata[23:16];
      mem[16'(m_addr + 16'd2)]   <= m_wdata[15:8];
      mem[16'(m_addr + 16'd3)]   <= m_wdata[7:0];
    end
  end

  // Fetch-only instances at READ_LAT 3 and 7
  logic [1:0]        lt_req;
  logic [1:0][31:0]  lt_addr;
  wire  [1:0]        lt_ready;
  wire  [1:0]        lt_err;
  wire  [1:0][31:0]  lt_rdata;

  function automatic logic [31:0] lat_word(input logic [15:0] a);
    return (a == 16'h0100) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_lat
    localparam int LAT = (k == 0) ? 3 : 7;
    logic        l_d_ready, l_d_err, l_m_en, l_m_we, l_busy;
    logic [31:0] l_d_rdata, l_m_wdata, l_m_rdata;
    logic [15:0] l_m_addr;
    logic [31:0] dl [LAT];
    mem_port_arbiter #(.ADDR_W(16), .READ_LAT(LAT), .STARVE_MAX(4)) u_lat (
      .mem_Clk(mem_Clk), .mem_Rst_n(mem_Rst_n),
      .if_req(lt_req[k]), .if_addr(lt_addr[k]), .if_ready(lt_ready[k]),
      .if_rdata(lt_rdata[k]), .if_err(lt_err[k]),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ready(l_d_ready), .d_rdata(l_d_rdata), .d_err(l_d_err),
      .m_en(l_m_en), .m_we(l_m_we), .m_addr(l_m_addr), .m_wdata(l_m_wdata), .m_rdata(l_m_rdata),
      .busy(l_busy)
    );
    always @(posedge mem_Clk) begin
      dl[0] <= (l_m_en && !l_m_we) ? lat_word(l_m_addr) : 32'h0;
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign l_m_rdata = dl[LAT-1];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_wr [int];

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 13) ^ (a >> 5));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int k;
    k = int'(a);
    if (ref_wr.exists(k)) return ref_wr[k];
    return {init_byte(k), init_byte(k + 1), init_byte(k + 2), init_byte(k + 3)};
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'h0000FFFC);
  endfunction

  task automatic tick;
    @(posedge mem_Clk);
    #1;
  endtask

  // Drive one fetch, wait for its ready pulse, return latency (-1 on timeout)
  task automatic run_fetch(input logic [31:0] a, output int cyc, output logic [31:0] rd, output logic e);
    bit ok = 0;
    if_addr = a; if_req = 1'b1; cyc = 1; rd = 'x; e = 1'bx;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick(); cyc++;
      if (if_ready) begin rd = if_rdata; e = if_err; ok = 1; end
    end
    if_req = 1'b0;
    if (!ok) cyc = -1;
    tick();
  endtask

  task automatic run_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd, output logic e);
    bit ok = 0;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; cyc = 1; rd = 'x; e = 1'bx;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick(); cyc++;
      if (d_ready) begin rd = d_rdata; e = d_err; ok = 1; end
    end
    d_req = 1'b0;
    if (!ok) cyc = -1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    mem_Rst_n = 1'b0;
    repeat (2) tick();
    total++; if ({if_ready, if_err, d_ready, d_err, m_en, m_we, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000000", {if_ready, if_err, d_ready, d_err, m_en, m_we, busy});
    end
    total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got if=%h d=%h want 0", if_rdata, d_rdata);
    end
    total++; if (m_addr !== 16'h0 || m_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", m_addr, m_wdata);
    end
    total++; if (lt_ready !== 2'b00 || lt_err !== 2'b00) begin
      bad++; $display("FAIL reset_lat_inst: got ready=%b err=%b want 0", lt_ready, lt_err);
    end
    mem_Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read;
    int c; logic [31:0] rd; logic e;
    run_fetch(32'h100, c, rd, e);
    total++; if (c !== 4) begin bad++; $display("FAIL fetch_latency: got %0d want 4", c); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata: got %h want deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL fetch_err: got %b want 0", e); end
  endtask

  task automatic test_store_load;
    int c; logic [31:0] rd; logic e;
    run_data(1'b1, 32'h200, 32'h12345678, c, rd, e);
    if (e === 1'b0) ref_wr[32'h200] = 32'h12345678;
    total++; if (c !== 3) begin bad++; $display("FAIL store_latency: got %0d want 3", c); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL store_err: got %b want 0", e); end
    run_data(1'b0, 32'h200, 32'h0, c, rd, e);
    total++; if (c !== 4) begin bad++; $display("FAIL load_latency: got %0d want 4", c); end
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL load_rdata: got %h want 12345678", rd); end
  endtask

  task automatic test_bad_addr;
    int c, men0; logic [31:0] rd; logic e;
    logic [31:0] bad_a [3] = '{32'h202, 32'hFFFE, 32'h10000};
    men0 = m_en_cnt;
    foreach (bad_a[i]) begin
      run_data(logic'(i[0]), bad_a[i], 32'hCAFEF00D, c, rd, e);
      total++; if (c !== 2 || e !== 1'b1 || rd !== 32'h0) begin
        bad++; $display("FAIL bad_data_%h: got lat=%0d err=%b rd=%h want 2/1/0", bad_a[i], c, e, rd);
      end
    end
    run_fetch(32'h0001_0000, c, rd, e);
    total++; if (c !== 2 || e !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL bad_fetch: got lat=%0d err=%b rd=%h want 2/1/0", c, e, rd);
    end
    total++; if (m_en_cnt !== men0) begin bad++; $display("FAIL bad_no_access: got %0d m_en want 0", m_en_cnt - men0); end
    // Highest legal word
    run_data(1'b1, 32'hFFFC, 32'hA1B2C3D4, c, rd, e);
    if (e === 1'b0) ref_wr[32'hFFFC] = 32'hA1B2C3D4;
    total++; if (c !== 3 || e !== 1'b0) begin bad++; $display("FAIL top_store: got lat=%0d err=%b want 3/0", c, e); end
    run_data(1'b0, 32'hFFFC, 32'h0, c, rd, e);
    total++; if (rd !== exp_word(32'hFFFC) || e !== 1'b0) begin
      bad++; $display("FAIL top_load: got %h err=%b want %h", rd, e, exp_word(32'hFFFC));
    end
  endtask

  task automatic test_starvation;
    byte got_q[$];
    byte want;
    int  sc = 0;
    men_q.delete();
    d_we = 1'b0; d_addr = 32'h1000; d_wdata = 32'h0; if_addr = 32'h100;
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 10; i++) begin
      tick();
      total++; if (if_ready && d_ready) begin bad++; $display("FAIL dual_ready: got both want one"); end
      if (d_ready) begin
        got_q.push_back("D");
        total++; if (d_rdata !== exp_word(d_addr)) begin
          bad++; $display("FAIL stream_load_%h: got %h want %h", d_addr, d_rdata, exp_word(d_addr));
        end
        d_addr = d_addr + 32'd4;
      end
      if (if_ready) begin
        got_q.push_back("F");
        total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL stream_fetch: got %h want deadbeef", if_rdata); end
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    tick(); tick();
    total++; if (got_q.size() != 10) begin bad++; $display("FAIL starve_count: got %0d grants want 10", got_q.size()); end
    for (int g = 0; g < got_q.size(); g++) begin
      if (sc == 4) begin want = "F"; sc = 0; end else begin want = "D"; sc++; end
      total++; if (got_q[g] != want) begin bad++; $display("FAIL starve_order_%0d: got %c want %c", g, got_q[g], want); end
    end
    for (int g = 1; g < men_q.size(); g++) begin
      total++; if (men_q[g] - men_q[g-1] != 4) begin
        bad++; $display("FAIL issue_spacing_%0d: got %0d want 4", g, men_q[g] - men_q[g-1]);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    int c; logic [31:0] rd; logic e;
    if_addr = 32'h100; if_req = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b1 || m_en !== 1'b0) begin bad++; $display("FAIL wait_state: got busy=%b m_en=%b want 1/0", busy, m_en); end
    mem_Rst_n = 1'b0; if_req = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || m_en !== 1'b0 || if_ready !== 1'b0) begin
      bad++; $display("FAIL rst_wait: got busy=%b m_en=%b rdy=%b want 0/0/0", busy, m_en, if_ready);
    end
    tick();
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL rst_no_ready: got %b want 0", if_ready); end
    mem_Rst_n = 1'b1;
    tick();
    run_fetch(32'h100, c, rd, e);
    total++; if (c !== 4 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
      bad++; $display("FAIL post_rst_fetch: got lat=%0d rd=%h err=%b want 4/deadbeef/0", c, rd, e);
    end
  endtask

  task automatic test_read_latency;
    int lat [2] = '{0, 0};
    int want [2] = '{6, 10};
    logic [31:0] rd [2];
    logic        er [2];
    int c = 1;
    lt_addr[0] = 32'h100; lt_addr[1] = 32'h100; lt_req = 2'b11;
    for (int i = 0; i < 30 && (lat[0] == 0 || lat[1] == 0); i++) begin
      tick(); c++;
      for (int k = 0; k < 2; k++)
        if (lt_ready[k] && lat[k] == 0) begin lat[k] = c; rd[k] = lt_rdata[k]; er[k] = lt_err[k]; lt_req[k] = 1'b0; end
    end
    lt_req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      total++; if (lat[k] != want[k]) begin bad++; $display("FAIL lat_sweep_%0d: got %0d want %0d", k, lat[k], want[k]); end
      total++; if (rd[k] !== 32'hDEADBEEF || er[k] !== 1'b0) begin
        bad++; $display("FAIL lat_data_%0d: got %h err=%b want deadbeef/0", k, rd[k], er[k]);
      end
    end
    tick();
  endtask

  task automatic rand_fetch_agent;
    logic [31:0] a, wrd; logic we, ok;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      case ($urandom_range(0, 9))
        0:       a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        1:       a = 32'h0001_0000 + 32'($urandom_range(0, 65535)) * 4;
        default: a = 32'($urandom_range(0, 1023)) * 4;
      endcase
      if_addr = a; if_req = 1'b1; ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        tick();
        if (if_ready) begin
          ok = 1; we = addr_bad(a); wrd = we ? 32'h0 : exp_word(a);
          total++; if (if_err !== we || if_rdata !== wrd) begin
            bad++; $display("FAIL rnd_fetch_%h: got %h err=%b want %h err=%b", a, if_rdata, if_err, wrd, we);
          end
        end
      end
      if_req = 1'b0;
      if (!ok) begin total++; bad++; $display("FAIL rnd_fetch_timeout_%h: got no ready want ready", a); end
    end
  endtask

  task automatic rand_data_agent;
    logic [31:0] a, wd, wrd; logic we, eb, ok;
    for (int n = 0; n < 35; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 7))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255)) + 32'($urandom_range(1, 3));
        1:       a = 32'hFFFF_FFFC - 32'($urandom_range(0, 16)) * 4;
        default: a = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      endcase
      we = 1'($urandom_range(0, 1)); wd = $urandom;
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        tick();
        if (if_ready && d_ready) begin total++; bad++; $display("FAIL rnd_dual_ready: got both want one"); end
        if (d_ready) begin
          ok = 1; eb = addr_bad(a); wrd = exp_word(a);
          total++; if (d_err !== eb) begin bad++; $display("FAIL rnd_data_err_%h: got %b want %b", a, d_err, eb); end
          if (!we || eb) begin
            if (eb) wrd = 32'h0;
            total++; if (d_rdata !== wrd) begin bad++; $display("FAIL rnd_load_%h: got %h want %h", a, d_rdata, wrd); end
          end else begin
            ref_wr[int'(a)] = wd;
          end
        end
      end
      d_req = 1'b0;
      if (!ok) begin total++; bad++; $display("FAIL rnd_data_timeout_%h: got no ready want ready", a); end
    end
  endtask

  task automatic test_random;
    fork
      rand_fetch_agent();
      rand_data_agent();
    join
    repeat (3) tick();
  endtask

  initial begin
    mem_Rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    lt_req = 2'b00; lt_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
    mem[16'h100] = 8'hDE; mem[16'h101] = 8'hAD; mem[16'h102] = 8'hBE; mem[16'h103] = 8'hEF;
    ref_wr[32'h100] = 32'hDEADBEEF;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_bad_addr();
    test_starvation();
    test_reset_in_wait();
    test_read_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
